// File: rtl/lock_pkg.sv
// Shared definitions for the lock datapath: lockout timer state encoding,
// default board clock rate and width helpers used by controller, checker and timer.
package lock_pkg;

    localparam int DEFAULT_CLK_HZ = 50_000_000;

    typedef enum logic [1:0] {
        LT_IDLE     = 2'd0,
        LT_COUNT    = 2'd1,
        LT_WAIT_LOW = 2'd2
    } lockout_state_e;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int secs_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed for a modulo-n counter (0..n-1), never less than one bit.
    function automatic int count_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lockout_timer_if.sv
// Sleep handshake between the lock controller (master) and the lockout timer (slave),
// plus the seconds-remaining value fed to the display path.
interface lockout_timer_if #(
    parameter int SECS_W = 6
) ();

    logic              sleep;
    logic              unlock;
    logic              end_sleep;
    logic              active;
    logic [SECS_W-1:0] secs_left;

    modport master (
        output sleep,
        output unlock,
        input  end_sleep,
        input  active,
        input  secs_left
    );

    modport slave (
        input  sleep,
        input  unlock,
        output end_sleep,
        output active,
        output secs_left
    );

endinterface

// File: rtl/lockout_timer_sec_tick.sv
// sec_tick_gen: free-running prescaler producing a one-cycle tick every CLK_HZ
// enabled cycles; a synchronous clear takes priority and suppresses the tick.
module sec_tick_gen
    import lock_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
    input  logic clk,
    input  logic system_reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CNT_W = count_width(CLK_HZ);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        tick_o  = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            if (count_q == LAST) begin
                count_d = '0;
                tick_o  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (system_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lockout_timer.sv
// Lockout timer: times the controller's sleep period in whole seconds and returns a
// one-cycle end_sleep. Define LOCKOUT_BACKOFF_EN for doubling durations per lockout.
module lockout_timer
    import lock_pkg::*;
#(
    parameter int CLK_HZ    = DEFAULT_CLK_HZ,
    parameter int BASE_SECS = 5,
    parameter int MAX_SECS  = 60,
    parameter int MAX_LEVEL = 3
) (
    input  logic            clk,
    input  logic            system_reset,
    lockout_timer_if.slave  tim
);

    localparam int SECS_W = secs_width(MAX_SECS);
    localparam int LVL_W  = secs_width(MAX_LEVEL);

    if (BASE_SECS <= 0) begin : g_bad_base
        $error("lockout_timer: BASE_SECS must be at least 1");
    end

    // Shift the base duration by the backoff level, saturating at the ceiling.
    function automatic logic [SECS_W-1:0] clamp_dur(input int lvl);
        longint d;
        d = longint'(BASE_SECS) << lvl;
        if (d > longint'(MAX_SECS)) begin
            d = longint'(MAX_SECS);
        end
        return SECS_W'(d);
    endfunction

    lockout_state_e    state_q, state_d;
    logic              sleep_q;
    logic [SECS_W-1:0] secs_left_q, secs_left_d;
    logic              active_q, active_d;
    logic              end_sleep_q, end_sleep_d;

    logic              arm;
    logic              abort;
    logic              expire;
    logic              tick;
    logic              presc_clear;
    logic              presc_enable;
    logic [SECS_W-1:0] dur;

    assign arm          = tim.sleep & ~sleep_q;
    assign abort        = (state_q == LT_COUNT) && !tim.sleep;
    assign presc_enable = (state_q == LT_COUNT);
    assign presc_clear  = (state_q != LT_COUNT) || abort;
    assign expire       = (state_q == LT_COUNT) && tim.sleep && tick
                          && (secs_left_q <= SECS_W'(1));

    sec_tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tick (
        .clk         (clk),
        .system_reset(system_reset),
        .clear_i     (presc_clear),
        .enable_i    (presc_enable),
        .tick_o      (tick)
    );

`ifdef LOCKOUT_BACKOFF_EN
    logic [LVL_W-1:0] level_q, level_d;

    // An unlock in the same cycle as an expiry must still leave the level at zero.
    always_comb begin
        level_d = level_q;
        if (expire && (level_q < LVL_W'(MAX_LEVEL))) begin
            level_d = level_q + 1'b1;
        end
        if (tim.unlock) begin
            level_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (system_reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign dur = clamp_dur(int'(level_q));
`else
    logic unused_unlock;
    localparam int unused_lvl_w = LVL_W;
    assign unused_unlock = tim.unlock;
    assign dur           = clamp_dur(0);
`endif

    always_comb begin
        state_d     = state_q;
        secs_left_d = secs_left_q;
        active_d    = active_q;
        end_sleep_d = 1'b0;
        case (state_q)
            LT_IDLE: begin
                if (arm) begin
                    secs_left_d = dur;
                    active_d    = 1'b1;
                    state_d     = LT_COUNT;
                end
            end
            LT_COUNT: begin
                if (abort) begin
                    secs_left_d = '0;
                    active_d    = 1'b0;
                    state_d     = LT_IDLE;
                end else if (expire) begin
                    secs_left_d = '0;
                    active_d    = 1'b0;
                    end_sleep_d = 1'b1;
                    state_d     = LT_WAIT_LOW;
                end else if (tick) begin
                    secs_left_d = secs_left_q - 1'b1;
                end
            end
            LT_WAIT_LOW: begin
                // Holding sleep past the pulse must not re-arm a second lockout.
                if (!tim.sleep) begin
                    state_d = LT_IDLE;
                end
            end
            default: begin
                secs_left_d = '0;
                active_d    = 1'b0;
                state_d     = LT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (system_reset) begin
            state_q     <= LT_IDLE;
            sleep_q     <= 1'b0;
            secs_left_q <= '0;
            active_q    <= 1'b0;
            end_sleep_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sleep_q     <= tim.sleep;
            secs_left_q <= secs_left_d;
            active_q    <= active_d;
            end_sleep_q <= end_sleep_d;
        end
    end

    assign tim.end_sleep = end_sleep_q;
    assign tim.active    = active_q;
    assign tim.secs_left = secs_left_q;

endmodule

// File: tb/tb_lockout_timer.sv
// Testbench for lockout_timer with CLK_HZ=4, BASE_SECS=2, MAX_SECS=10, MAX_LEVEL=3;
// follows LOCKOUT_BACKOFF_EN so the same bench covers both builds.
module tb_lockout_timer;
    import lock_pkg::*;

    localparam int CLK_HZ    = 4;
    localparam int BASE_SECS = 2;
    localparam int MAX_SECS  = 10;
    localparam int MAX_LEVEL = 3;
    localparam int SECS_W    = secs_width(MAX_SECS);
`ifdef LOCKOUT_BACKOFF_EN
    localparam bit BACKOFF = 1'b1;
`else
    localparam bit BACKOFF = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    lockout_timer_if #(.SECS_W(SECS_W)) tim ();

    lockout_timer #(
        .CLK_HZ   (CLK_HZ),
        .BASE_SECS(BASE_SECS),
        .MAX_SECS (MAX_SECS),
        .MAX_LEVEL(MAX_LEVEL)
    ) dut (
        .clk         (clk),
        .system_reset(rst),
        .tim         (tim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model in terms of elapsed cycles since the arming edge.
    bit m_valid;
    bit m_busy;
    bit m_wait;
    bit m_prev;
    bit m_pulse;
    int m_level;
    int m_elapsed;
    int m_dur;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_wait  = 1'b0;
            m_prev  = 1'b0;
            m_pulse = 1'b0;
            m_level = 0;
        end else if (m_valid) begin
            m_pulse = 1'b0;
            if (m_busy) begin
                if (!tim.sleep) begin
                    m_busy = 1'b0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == m_dur * CLK_HZ) begin
                        m_busy  = 1'b0;
                        m_pulse = 1'b1;
                        m_wait  = 1'b1;
                        if (BACKOFF && m_level < MAX_LEVEL) m_level++;
                    end
                end
            end else if (m_wait) begin
                if (!tim.sleep) m_wait = 1'b0;
            end else if (tim.sleep && !m_prev) begin
                m_busy    = 1'b1;
                m_elapsed = 0;
                m_dur     = BASE_SECS << m_level;
                if (m_dur > MAX_SECS) m_dur = MAX_SECS;
            end
            if (BACKOFF && tim.unlock) m_level = 0;
            m_prev = tim.sleep;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model.end_sleep", int'(tim.end_sleep), int'(m_pulse));
            checkOutput("model.active", int'(tim.active), int'(m_busy));
            checkOutput("model.secs_left", int'(tim.secs_left),
                        m_busy ? (m_dur - m_elapsed / CLK_HZ) : 0);
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Raise sleep after a negedge and count cycles from the arming edge to end_sleep.
    task automatic applyStimulus(input string name, input int expected);
        int  cycles;
        bit  done;
        cycles = 0;
        done   = 1'b0;
        tim.sleep = 1'b1;
        while (!done && cycles < 200) begin
            @(negedge clk);
            #1;
            if (tim.end_sleep) done = 1'b1;
            else cycles++;
        end
        if (!done) begin
            checkOutput({name, ".timeout"}, cycles, expected);
        end else begin
            checkOutput(name, cycles, expected);
        end
        waitCycles(1);
        tim.sleep = 1'b0;
        waitCycles(2);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        m_valid    = 1'b0;
        rst        = 1'b1;
        tim.sleep  = 1'b1;
        tim.unlock = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset.end_sleep", int'(tim.end_sleep), 0);
        checkOutput("reset.active", int'(tim.active), 0);
        checkOutput("reset.secs_left", int'(tim.secs_left), 0);
        rst = 1'b0;

        // First lockout arms on the edge after release, sleep already high.
        waitCycles(1);
        checkOutput("basic.secs_e0", int'(tim.secs_left), 2);
        checkOutput("basic.active_e0", int'(tim.active), 1);
        waitCycles(4);
        checkOutput("basic.secs_e4", int'(tim.secs_left), 1);
        checkOutput("basic.active_e4", int'(tim.active), 1);
        waitCycles(4);
        checkOutput("basic.end_e8", int'(tim.end_sleep), 1);
        checkOutput("basic.secs_e8", int'(tim.secs_left), 0);
        checkOutput("basic.active_e8", int'(tim.active), 0);
        waitCycles(1);
        checkOutput("basic.end_e9", int'(tim.end_sleep), 0);

        waitCycles(4);
        checkOutput("hold.active", int'(tim.active), 0);
        tim.sleep = 1'b0;
        waitCycles(2);

        applyStimulus("len.second", BACKOFF ? 16 : 8);
        applyStimulus("len.third", BACKOFF ? 32 : 8);
        applyStimulus("len.fourth", BACKOFF ? 40 : 8);
        applyStimulus("len.saturated", BACKOFF ? 40 : 8);

        tim.sleep = 1'b1;
        waitCycles(5);
        tim.sleep = 1'b0;
        waitCycles(1);
        checkOutput("abort.secs", int'(tim.secs_left), 0);
        checkOutput("abort.active", int'(tim.active), 0);
        checkOutput("abort.end", int'(tim.end_sleep), 0);
        waitCycles(3);
        applyStimulus("len.after_abort", BACKOFF ? 40 : 8);

        tim.unlock = 1'b1;
        waitCycles(1);
        tim.unlock = 1'b0;
        waitCycles(1);
        applyStimulus("len.after_unlock", 8);

        // Unlock lands on the very edge the lockout expires.
        tim.sleep = 1'b1;
        waitCycles(BACKOFF ? 16 : 8);
        tim.unlock = 1'b1;
        waitCycles(1);
        tim.unlock = 1'b0;
        checkOutput("same_cycle.end", int'(tim.end_sleep), 1);
        waitCycles(1);
        tim.sleep = 1'b0;
        waitCycles(2);
        applyStimulus("len.after_same_cycle", 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
